hd63701_sci_fifo: RTL and testbench
===================================

// Module: hd63701_sci_fifo
// PURPOSE
//  Parametrised successor of the HD63701 built-in SCI: async serial TX/RX with
//  programmable bit period, configurable data width, RX/TX FIFOs, framing/overrun
//  detection and false-start rejection. Sits on the core bus beside the timer and
//  I/O port; iod is routed through the built-in data selector when en_sci is high.
// PARAMETERS
//  BASE_ADDR   16'h0010  address of RMCR; TRCSR=+1, RDR=+2, TDR=+3
//  DATA_BITS   8         data bits per frame, 5..8, LSB first
//  RX_DEPTH    4         RX FIFO entries, power of 2, >=2
//  TX_DEPTH    4         TX FIFO entries, power of 2, >=2
//  DIV_BASE    16        clocks per bit when RMCR[1:0]=0
// PORTS
//  mcu_clx2      in   1   clock; all state updates on posedge
//  mcu_rst       in   1   asynchronous active-high reset
//  mcu_ad        in   16  core address
//  mcu_wr        in   1   1 = write cycle, 0 = read cycle
//  mcu_do        in   8   core write data
//  rx            in   1   serial input, async, idle high
//  tx            out  1   serial output, idle high
//  te            out  1   TRCSR[1], lets the top level mux tx onto port 2 bit 4
//  mcu_irq2_sci  out  1   level interrupt request to the core
//  en_sci        out  1   mcu_ad in BASE_ADDR..BASE_ADDR+3
//  iod           out  8   register read data, combinational from mcu_ad
// BEHAVIOUR
//  Reset: RMCR=0, TRCSR=0, FIFOs empty, ORFE=0, tx=1, both FSMs IDLE, irq=0.
//  Bit period P = DIV_BASE << (3*RMCR[1:0]), i.e. 16/128/1024/8192 clocks.
//  Reads: RMCR; TRCSR = {RDRF,ORFE,TDRE,TRCSR[4:1],0}; RDR = RX FIFO head,
//   zero-extended; 0 when empty; TDR reads the last written value.
//  RDRF = RX FIFO not empty. TDRE = TX FIFO not full.
//  RDR pop: on the first clock of a contiguous run of read cycles at BASE+2.
//   The pop also clears ORFE. A pop while empty has no effect.
//  TDR write pushes mcu_do[DATA_BITS-1:0]. A push while full is dropped silently.
//  TRCSR write updates bits [4:0] only. Bit 0 (WU) reads as 0.
//  irq = (TRCSR[4] & (RDRF|ORFE)) | (TRCSR[2] & TDRE).
//  rx passes through a 2-flop synchroniser; all RX logic uses the synced value.
//  RX FSM (runs only while RE=TRCSR[3]):
//   IDLE  : falling edge of synced rx -> START, counter=0.
//   START : at count P/2, rx=1 -> IDLE (false start); rx=0 -> DATA.
//   DATA  : sample every P clocks, DATA_BITS samples, shifted in LSB first -> STOP.
//   STOP  : sample after P clocks, then go to IDLE.
//    rx=1, FIFO not full -> push.  rx=1, FIFO full -> drop data, set ORFE.
//    rx=0 -> push if room (framing error), set ORFE.
//   RE=0 forces IDLE at once; the partial frame is discarded and FIFO contents kept.
//  TX FSM (runs only while TE=1):
//   IDLE  : FIFO not empty -> pop, tx=0, START.
//   START, DATA_BITS x DATA, STOP: each held P clocks.
//   After STOP -> IDLE; the next frame starts with no extra idle bit.
//   TE=0 mid-frame: tx=1 next clock, FSM IDLE, the popped byte is lost.
//   RMCR writes take effect at the next bit boundary.
//  Push and pop in the same clock on the same FIFO are both performed; level unchanged.
//  An RX push and a RDR pop in the same clock are legal.
// TESTING
//  1 TE=1, RMCR=0, write TDR=A5 -> tx 0 for 16 clk, then 1,0,1,0,0,1,0,1
//    at 16 clk each, stop bit 1 for 16 clk. TDRE stays 1.
//  2 TE=0, write 11,22,33,44,55 -> TDRE=0 after the 4th write.
//    Set TE=1 -> 4 back-to-back frames 11..44; 55 is never sent.
//  3 RE=1, RIE=1, drive frame 3C at P=16 -> RDRF=1 and irq=1 after stop sample.
//    Read RDR -> 3C, RDRF=0, irq=0.
//  4 Five frames 01..05, no reads -> ORFE=1 after the 5th.
//    Reads return 01,02,03,04. ORFE clears on the first read.
//  5 Frame 7E with stop bit 0 -> ORFE=1, RDR=7E.
//    6-clock low glitch on rx -> nothing received.
//  6 Assert mcu_rst mid-TX and mid-RX -> tx=1 and all registers at reset values
//    immediately. The first frame after reset is correct.

Source files
------------

// File: rtl/hd63701_sci_fifo.sv
// Generic synchronous FIFO used for the SCI receive and transmit queues.
// Latency: a push is visible at out_dat one clock later; a pop takes effect in the same clock.
// Backpressure: in_rdy drops when full, and out_vld drops when empty.
module sci_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         mcu_clx2,
  input  logic         mcu_rst,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         push;
  logic         pop;

  // The pointers carry one extra wrap bit so that full and empty can be told apart.
  assign in_rdy  = (wr_ptr ^ rd_ptr) != {1'b1, {AW{1'b0}}};
  assign out_vld = wr_ptr != rd_ptr;
  assign push    = in_vld & in_rdy;
  assign pop     = out_rdy & out_vld;
  assign out_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge mcu_clx2 or posedge mcu_rst) begin
    if (mcu_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge mcu_clx2) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_dat;
  end
endmodule

// SCI with a programmable bit period and RX/TX FIFOs, mapped at BASE_ADDR..BASE_ADDR+3.
// Latency: register reads are combinational; RX data lands in the FIFO at the stop-bit sample.
// Backpressure: a TDR write to a full FIFO is dropped, and an RX frame arriving at a full FIFO sets ORFE.
module hd63701_sci_fifo #(
  parameter logic [15:0] BASE_ADDR = 16'h0010,
  parameter int          DATA_BITS = 8,
  parameter int          RX_DEPTH  = 4,
  parameter int          TX_DEPTH  = 4,
  parameter int          DIV_BASE  = 16
) (
  input  logic        mcu_clx2,
  input  logic        mcu_rst,
  input  logic [15:0] mcu_ad,
  input  logic        mcu_wr,
  input  logic [7:0]  mcu_do,
  input  logic        rx,
  output logic        tx,
  output logic        te,
  output logic        mcu_irq2_sci,
  output logic        en_sci,
  output logic [7:0]  iod
);
  localparam int           CW       = $clog2(DIV_BASE * 512) + 1;
  localparam logic [3:0]   LAST_BIT = 4'(DATA_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} sci_state_t;

  function automatic logic [CW-1:0] bit_period(input logic [1:0] sel);
    logic [CW-1:0] p;
    case (sel)
      2'd0:    p = CW'(DIV_BASE);
      2'd1:    p = CW'(DIV_BASE * 8);
      2'd2:    p = CW'(DIV_BASE * 64);
      default: p = CW'(DIV_BASE * 512);
    endcase
    return p;
  endfunction

  logic [15:0]          reg_off;
  logic [7:0]           rmcr;
  logic [4:1]           trcsr_q;
  logic [7:0]           tdr_last;
  logic                 orfe;
  logic                 rd_rdr_q;
  logic                 wr_sel;
  logic                 rd_rdr;
  logic                 rdr_pop;
  logic                 wr_tdr;
  logic                 re;

  logic                 rxf_in_vld;
  logic                 rxf_in_rdy;
  logic                 rxf_out_vld;
  logic [DATA_BITS-1:0] rxf_out_dat;
  logic                 txf_in_rdy;
  logic                 txf_out_vld;
  logic                 txf_pop;
  logic [DATA_BITS-1:0] txf_out_dat;

  logic                 rx_s1, rx_s2, rx_s3;
  sci_state_t           rx_state;
  logic [CW-1:0]        rx_cnt;
  logic [CW-1:0]        rx_per;
  logic [3:0]           rx_bits;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_done;

  sci_state_t           tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [CW-1:0]        tx_per;
  logic [3:0]           tx_bits;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_done;

  assign reg_off = mcu_ad - BASE_ADDR;
  assign en_sci  = reg_off < 16'd4;
  assign wr_sel  = en_sci & mcu_wr;
  assign wr_tdr  = wr_sel & (reg_off[1:0] == 2'd3);
  assign rd_rdr  = en_sci & ~mcu_wr & (reg_off[1:0] == 2'd2);
  // A multi-cycle read of RDR pops only once, on its first clock.
  assign rdr_pop = rd_rdr & ~rd_rdr_q;
  assign te      = trcsr_q[1];
  assign re      = trcsr_q[3];

  assign mcu_irq2_sci = (trcsr_q[4] & (rxf_out_vld | orfe)) | (trcsr_q[2] & txf_in_rdy);

  always_comb begin
    iod = 8'h00;
    if (en_sci) begin
      case (reg_off[1:0])
        2'd0:    iod = rmcr;
        2'd1:    iod = {rxf_out_vld, orfe, txf_in_rdy, trcsr_q, 1'b0};
        2'd2:    iod = rxf_out_vld ? 8'(rxf_out_dat) : 8'h00;
        default: iod = tdr_last;
      endcase
    end
  end

  always_ff @(posedge mcu_clx2 or posedge mcu_rst) begin
    if (mcu_rst) begin
      rmcr     <= 8'h00;
      trcsr_q  <= 4'h0;
      tdr_last <= 8'h00;
      rd_rdr_q <= 1'b0;
      orfe     <= 1'b0;
    end else begin
      rd_rdr_q <= rd_rdr;
      if (wr_sel && reg_off[1:0] == 2'd0) rmcr    <= mcu_do;
      if (wr_sel && reg_off[1:0] == 2'd1) trcsr_q <= mcu_do[4:1];
      if (wr_tdr)                         tdr_last <= mcu_do;
      // A new error in the same clock as a pop wins, so the error is not lost.
      if (rxf_in_vld && (!rx_s2 || !rxf_in_rdy)) orfe <= 1'b1;
      else if (rdr_pop && rxf_out_vld)           orfe <= 1'b0;
    end
  end

  sci_fifo #(.W(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .mcu_clx2 (mcu_clx2),
    .mcu_rst  (mcu_rst),
    .in_vld   (rxf_in_vld),
    .in_rdy   (rxf_in_rdy),
    .in_dat   (rx_shift),
    .out_vld  (rxf_out_vld),
    .out_rdy  (rdr_pop),
    .out_dat  (rxf_out_dat)
  );

  sci_fifo #(.W(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .mcu_clx2 (mcu_clx2),
    .mcu_rst  (mcu_rst),
    .in_vld   (wr_tdr),
    .in_rdy   (txf_in_rdy),
    .in_dat   (mcu_do[DATA_BITS-1:0]),
    .out_vld  (txf_out_vld),
    .out_rdy  (txf_pop),
    .out_dat  (txf_out_dat)
  );

  // The receiver sees only the synchronised line; rx_s3 is kept for falling-edge detection.
  assign rx_done    = rx_cnt == rx_per - 1'b1;
  assign rxf_in_vld = re & (rx_state == S_STOP) & rx_done;

  always_ff @(posedge mcu_clx2 or posedge mcu_rst) begin
    if (mcu_rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_per   <= '0;
      rx_bits  <= 4'h0;
      rx_shift <= '0;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
      if (!re) begin
        rx_state <= S_IDLE;
        rx_cnt   <= '0;
      end else begin
        case (rx_state)
          S_IDLE: begin
            if (rx_s3 && !rx_s2) begin
              rx_state <= S_START;
              rx_cnt   <= '0;
              rx_per   <= bit_period(rmcr[1:0]);
            end
          end
          S_START: begin
            if (rx_cnt == (rx_per >> 1)) begin
              rx_cnt  <= '0;
              rx_bits <= 4'h0;
              rx_per  <= bit_period(rmcr[1:0]);
              rx_state <= rx_s2 ? S_IDLE : S_DATA;
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
          S_DATA: begin
            if (rx_done) begin
              rx_cnt   <= '0;
              rx_per   <= bit_period(rmcr[1:0]);
              rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
              rx_bits  <= rx_bits + 1'b1;
              if (rx_bits == LAST_BIT) rx_state <= S_STOP;
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
          default: begin
            if (rx_done) begin
              rx_cnt   <= '0;
              rx_state <= S_IDLE;
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
        endcase
      end
    end
  end

  // A pop at the end of the stop bit chains the next frame with no idle gap.
  assign tx_done = tx_cnt == tx_per - 1'b1;
  assign txf_pop = te & txf_out_vld & ((tx_state == S_IDLE) | ((tx_state == S_STOP) & tx_done));

  always_ff @(posedge mcu_clx2 or posedge mcu_rst) begin
    if (mcu_rst) begin
      tx       <= 1'b1;
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_per   <= '0;
      tx_bits  <= 4'h0;
      tx_shift <= '0;
    end else if (!te) begin
      tx       <= 1'b1;
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
    end else begin
      case (tx_state)
        S_IDLE: begin
          if (txf_out_vld) begin
            tx       <= 1'b0;
            tx_state <= S_START;
            tx_cnt   <= '0;
            tx_per   <= bit_period(rmcr[1:0]);
            tx_shift <= txf_out_dat;
          end
        end
        S_START: begin
          if (tx_done) begin
            tx       <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_bits  <= 4'h0;
            tx_cnt   <= '0;
            tx_per   <= bit_period(rmcr[1:0]);
            tx_state <= S_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (tx_done) begin
            tx_cnt  <= '0;
            tx_per  <= bit_period(rmcr[1:0]);
            tx_bits <= tx_bits + 1'b1;
            if (tx_bits == LAST_BIT) begin
              tx       <= 1'b1;
              tx_state <= S_STOP;
            end else begin
              tx       <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: begin
          if (tx_done) begin
            tx_cnt <= '0;
            tx_per <= bit_period(rmcr[1:0]);
            if (txf_out_vld) begin
              tx       <= 1'b0;
              tx_shift <= txf_out_dat;
              tx_state <= S_START;
            end else begin
              tx_state <= S_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hd63701_sci_fifo.sv
// Self-checking bench for hd63701_sci_fifo: directed frames plus randomized traffic.
// A queue-based model of the two FIFOs supplies every expected value.
module tb_hd63701_sci_fifo;
  localparam logic [15:0] A_RMCR  = 16'h0010;
  localparam logic [15:0] A_TRCSR = 16'h0011;
  localparam logic [15:0] A_RDR   = 16'h0012;
  localparam logic [15:0] A_TDR   = 16'h0013;
  localparam logic [15:0] A_IDLE  = 16'h0000;
  localparam int          DEPTH   = 4;

  logic        mcu_clx2;
  logic        mcu_rst;
  logic [15:0] mcu_ad;
  logic        mcu_wr;
  logic [7:0]  mcu_do;
  logic        rx;
  logic        tx;
  logic        te;
  logic        mcu_irq2_sci;
  logic        en_sci;
  logic [7:0]  iod;

  int          n_checks;
  int          n_errors;
  byte unsigned rx_q[$];
  byte unsigned tx_q[$];
  bit          m_orfe;

  hd63701_sci_fifo dut (
    .mcu_clx2     (mcu_clx2),
    .mcu_rst      (mcu_rst),
    .mcu_ad       (mcu_ad),
    .mcu_wr       (mcu_wr),
    .mcu_do       (mcu_do),
    .rx           (rx),
    .tx           (tx),
    .te           (te),
    .mcu_irq2_sci (mcu_irq2_sci),
    .en_sci       (en_sci),
    .iod          (iod)
  );

  initial mcu_clx2 = 1'b0;
  always #5 mcu_clx2 = ~mcu_clx2;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge mcu_clx2);
    mcu_ad = a; mcu_wr = 1'b1; mcu_do = d;
    @(negedge mcu_clx2);
    mcu_ad = A_IDLE; mcu_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    @(negedge mcu_clx2);
    mcu_ad = a; mcu_wr = 1'b0;
    #1 d = iod;
    @(negedge mcu_clx2);
    mcu_ad = A_IDLE;
  endtask

  // Receiver reference: four-entry queue, full drops, bad stop bits still stored if room.
  function automatic void model_rx(input byte unsigned d, input bit stop_ok);
    if (rx_q.size() < DEPTH) rx_q.push_back(d);
    else m_orfe = 1'b1;
    if (!stop_ok) m_orfe = 1'b1;
  endfunction

  task automatic rdr_check(input string tag);
    logic [7:0] v;
    logic [7:0] exp;
    bus_read(A_RDR, v);
    exp = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    check(tag, v, exp);
    if (rx_q.size() > 0) begin
      void'(rx_q.pop_front());
      m_orfe = 1'b0;
    end
  endtask

  task automatic status_check(input string tag);
    logic [7:0] v;
    bus_read(A_TRCSR, v);
    check({tag, "_rdrf"}, v[7], rx_q.size() > 0);
    check({tag, "_orfe"}, v[6], m_orfe);
  endtask

  task automatic rx_frame(input int p, input logic [7:0] d, input logic stop_b);
    @(negedge mcu_clx2);
    rx = 1'b0;
    repeat (p) @(negedge mcu_clx2);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (p) @(negedge mcu_clx2);
    end
    rx = stop_b;
    repeat (p) @(negedge mcu_clx2);
    rx = 1'b1;
  endtask

  // Waits for a start bit, then samples every clock of the ten bit cells.
  task automatic tx_capture(input int p, output logic [7:0] d, output int bad);
    int n;
    logic [9:0] fr;
    logic first;
    n = 0; bad = 0; d = 8'h00; fr = '0; first = 1'b0;
    @(negedge mcu_clx2);
    while (tx !== 1'b0 && n < 20 * p + 100) begin
      @(negedge mcu_clx2);
      n++;
    end
    if (tx !== 1'b0) begin
      bad = 999;
      return;
    end
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < p; c++) begin
        if (b != 0 || c != 0) @(negedge mcu_clx2);
        if (c == 0) first = tx;
        else if (tx !== first) bad++;
        if (c == p / 2) fr[b] = tx;
      end
    end
    if (fr[0] !== 1'b0) bad++;
    if (fr[9] !== 1'b1) bad++;
    d = fr[8:1];
  endtask

  task automatic idle_check(input string tag, input int cycles);
    int lows;
    lows = 0;
    repeat (cycles) begin
      @(negedge mcu_clx2);
      if (tx !== 1'b1) lows++;
    end
    check(tag, lows, 0);
  endtask

  logic [7:0] v;
  logic [7:0] d;
  int         bad;
  int         p;
  int         nf;
  logic [1:0] sel;
  logic [7:0] t2 [5];

  initial begin
    n_checks = 0; n_errors = 0; m_orfe = 1'b0;
    mcu_rst = 1'b1; mcu_ad = A_IDLE; mcu_wr = 1'b0; mcu_do = 8'h00; rx = 1'b1;
    repeat (3) @(negedge mcu_clx2);
    mcu_rst = 1'b0;

    // Reset state and address decode.
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_irq", mcu_irq2_sci, 1'b0);
    check("rst_te", te, 1'b0);
    bus_read(A_RMCR, v);  check("rst_rmcr", v, 8'h00);
    bus_read(A_TRCSR, v); check("rst_trcsr", v, 8'h20);
    bus_read(A_RDR, v);   check("rst_rdr", v, 8'h00);
    bus_read(A_TDR, v);   check("rst_tdr", v, 8'h00);
    @(negedge mcu_clx2);
    mcu_ad = A_RMCR - 16'd1; #1 check("en_below", en_sci, 1'b0);
    mcu_ad = A_TDR;          #1 check("en_top", en_sci, 1'b1);
    mcu_ad = A_TDR + 16'd1;  #1 check("en_above", en_sci, 1'b0);
    mcu_ad = A_IDLE;

    // Single A5 frame at P=16 with exact bit timing; TDRE stays set.
    bus_write(A_TRCSR, 8'h02);
    bus_write(A_TDR, 8'hA5);
    fork
      tx_capture(16, d, bad);
      bus_read(A_TRCSR, v);
    join
    check("t1_dat", d, 8'hA5);
    check("t1_shape", bad, 0);
    check("t1_tdre", v[5], 1'b1);
    bus_read(A_TDR, v); check("t1_tdr_rd", v, 8'hA5);

    // Fill the TX FIFO with TE=0; fifth write is dropped.
    t2 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    bus_write(A_TRCSR, 8'h04);
    #1 check("t2_irq_tie", mcu_irq2_sci, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bus_write(A_TDR, t2[i]);
      if (tx_q.size() < DEPTH) tx_q.push_back(t2[i]);
      bus_read(A_TRCSR, v);
      check("t2_tdre", v[5], tx_q.size() < DEPTH);
    end
    #1 check("t2_irq_full", mcu_irq2_sci, 1'b0);
    bus_write(A_TRCSR, 8'h02);
    while (tx_q.size() > 0) begin
      tx_capture(16, d, bad);
      check("t2_dat", d, tx_q.pop_front());
      check("t2_shape", bad, 0);
    end
    idle_check("t2_no_fifth", 48);
    bus_read(A_TDR, v); check("t2_tdr_rd", v, 8'h55);

    // Dropping TE mid-frame idles the line and loses the frame.
    bus_write(A_TDR, 8'h0F);
    repeat (40) @(negedge mcu_clx2);
    bus_write(A_TRCSR, 8'h00);
    @(negedge mcu_clx2);
    check("te_off_tx", tx, 1'b1);
    bus_write(A_TRCSR, 8'h02);
    idle_check("te_off_lost", 48);

    // Single RX frame with RIE.
    bus_write(A_TRCSR, 8'h18);
    rx_frame(16, 8'h3C, 1'b1); model_rx(8'h3C, 1'b1);
    status_check("t3_pre");
    #1 check("t3_irq_set", mcu_irq2_sci, 1'b1);
    rdr_check("t3_rdr");
    status_check("t3_post");
    #1 check("t3_irq_clr", mcu_irq2_sci, 1'b0);

    // Overrun on the fifth frame.
    for (int i = 1; i <= 5; i++) begin
      rx_frame(16, 8'(i), 1'b1);
      model_rx(8'(i), 1'b1);
    end
    status_check("t4_ovr");
    rdr_check("t4_rdr");
    status_check("t4_clr");
    for (int i = 0; i < 4; i++) rdr_check("t4_rdr");

    // Framing error, then a short glitch that must be rejected.
    rx_frame(16, 8'h7E, 1'b0); model_rx(8'h7E, 1'b0);
    repeat (16) @(negedge mcu_clx2);
    status_check("t5_fe");
    rdr_check("t5_rdr");
    @(negedge mcu_clx2);
    rx = 1'b0;
    repeat (6) @(negedge mcu_clx2);
    rx = 1'b1;
    repeat (48) @(negedge mcu_clx2);
    status_check("t5_glitch");

    // Randomized RX traffic at P=16 or P=128.
    for (int it = 0; it < 3; it++) begin
      sel = 2'($urandom_range(0, 1));
      bus_write(A_RMCR, {6'h00, sel});
      p = 16 << (3 * sel);
      nf = $urandom_range(1, 5);
      for (int f = 0; f < nf; f++) begin
        bit ok;
        d = 8'($urandom);
        ok = ($urandom_range(0, 4) != 0);
        rx_frame(p, d, ok);
        model_rx(d, ok);
        if (!ok) repeat (p) @(negedge mcu_clx2);
      end
      status_check("rnd_rx");
      while (rx_q.size() > 0) rdr_check("rnd_rdr");
      rdr_check("rnd_rdr_empty");
      status_check("rnd_rx_end");
    end

    // Randomized TX traffic.
    for (int it = 0; it < 2; it++) begin
      sel = 2'($urandom_range(0, 1));
      bus_write(A_TRCSR, 8'h00);
      bus_write(A_RMCR, {6'h00, sel});
      p = 16 << (3 * sel);
      nf = $urandom_range(1, 6);
      for (int f = 0; f < nf; f++) begin
        d = 8'($urandom);
        bus_write(A_TDR, d);
        if (tx_q.size() < DEPTH) tx_q.push_back(d);
      end
      bus_read(A_TRCSR, v);
      check("rnd_tdre", v[5], tx_q.size() < DEPTH);
      bus_write(A_TRCSR, 8'h02);
      while (tx_q.size() > 0) begin
        tx_capture(p, d, bad);
        check("rnd_tx_dat", d, tx_q.pop_front());
        check("rnd_tx_shape", bad, 0);
      end
      idle_check("rnd_tx_idle", 2 * p);
    end

    // Asynchronous reset in the middle of TX and RX frames.
    bus_write(A_RMCR, 8'hF0);
    bus_write(A_TRCSR, 8'h1A);
    bus_write(A_TDR, 8'h96);
    fork
      rx_frame(16, 8'h5A, 1'b1);
    join_none
    repeat (60) @(negedge mcu_clx2);
    #1 mcu_rst = 1'b1;
    #1;
    check("t6_tx", tx, 1'b1);
    check("t6_irq", mcu_irq2_sci, 1'b0);
    check("t6_te", te, 1'b0);
    mcu_ad = A_RMCR;  #1 check("t6_rmcr", iod, 8'h00);
    mcu_ad = A_TRCSR; #1 check("t6_trcsr", iod, 8'h20);
    mcu_ad = A_RDR;   #1 check("t6_rdr", iod, 8'h00);
    mcu_ad = A_IDLE;
    @(negedge mcu_clx2);
    mcu_rst = 1'b0;
    rx_q.delete();
    tx_q.delete();
    m_orfe = 1'b0;
    repeat (150) @(negedge mcu_clx2);
    bus_write(A_TRCSR, 8'h1A);
    bus_write(A_TDR, 8'hC3);
    tx_capture(16, d, bad);
    check("t6_tx_dat", d, 8'hC3);
    check("t6_tx_shape", bad, 0);
    rx_frame(16, 8'h81, 1'b1); model_rx(8'h81, 1'b1);
    status_check("t6_rx");
    rdr_check("t6_rdr_after");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
